// File: rtl/quadrilatero_instr_pkg.sv
// Quadrilatero matrix instruction encodings (custom-1 opcode), as casez patterns.
package quadrilatero_instr_pkg;

  // Fields: funct7 | rs2 | rs1 | funct3 | rd | opcode
  localparam logic [31:0] MMAQA_B  = 32'b0000000_?????_?????_000_?????_0101011;
  localparam logic [31:0] MMADA_H  = 32'b0000001_?????_?????_000_?????_0101011;
  localparam logic [31:0] MMASA_W  = 32'b0000010_?????_?????_000_?????_0101011;
  localparam logic [31:0] FMMACC_B = 32'b0000100_?????_?????_000_?????_0101011;
  localparam logic [31:0] FMMACC_H = 32'b0000101_?????_?????_000_?????_0101011;
  localparam logic [31:0] FMMACC_S = 32'b0000110_?????_?????_000_?????_0101011;
  localparam logic [31:0] MZERO    = 32'b0001000_?????_?????_000_?????_0101011;
  localparam logic [31:0] MLD_W    = 32'b0000000_?????_?????_001_?????_0101011;
  localparam logic [31:0] MST_B    = 32'b0000000_?????_?????_010_?????_0101011;
  localparam logic [31:0] MST_H    = 32'b0000001_?????_?????_010_?????_0101011;
  localparam logic [31:0] MST_W    = 32'b0000010_?????_?????_010_?????_0101011;
  localparam logic [31:0] MCFG     = 32'b0000000_?????_?????_011_?????_0101011;
  localparam logic [31:0] MCFGK    = 32'b0000001_?????_?????_011_?????_0101011;
  localparam logic [31:0] MCFGKI   = 32'b0000010_?????_?????_011_?????_0101011;
  localparam logic [31:0] MCFGM    = 32'b0000011_?????_?????_011_?????_0101011;
  localparam logic [31:0] MCFGMI   = 32'b0000100_?????_?????_011_?????_0101011;
  localparam logic [31:0] MCFGN    = 32'b0000101_?????_?????_011_?????_0101011;
  localparam logic [31:0] MCFGNI   = 32'b0000110_?????_?????_011_?????_0101011;

endpackage

// File: rtl/quadrilatero_pkg.sv
// Shared quadrilatero types: instruction classes, issue-queue entry, default response.
package quadrilatero_pkg;

  localparam int unsigned MAX_ID_WIDTH = 16;

  typedef enum logic [2:0] {
    NONE, MAC, FMAC, LOAD, STORE, ZERO, CFG
  } instr_class_e;

  // Ids narrower than MAX_ID_WIDTH are stored zero-extended.
  typedef struct packed {
    logic [31:0]             instr;
    logic [MAX_ID_WIDTH-1:0] id;
    instr_class_e            cls;
    logic                    committed;
    logic                    killed;
  } queue_entry_t;

  localparam xif_pkg::x_issue_resp_t ISSUE_RESP_DEFAULT = '0;

endpackage

// File: rtl/xif_pkg.sv
// Response type of the core-V eXtension interface issue port.
package xif_pkg;

  typedef struct packed {
    logic       accept;
    logic       writeback;
    logic       dualwrite;
    logic [2:0] dualread;
    logic       loadstore;
    logic       ecswrite;
    logic       exc;
  } x_issue_resp_t;

endpackage

// File: rtl/quadrilatero_xif_issue_stage_if.sv
// Issue / commit / dispatch bundle of the quadrilatero XIF issue stage.
interface quadrilatero_xif_issue_stage_if #(
  parameter int unsigned ID_WIDTH = 4
);
  import quadrilatero_pkg::*;

  // Issue and dispatch transfer on a clock edge where valid & ready are both high;
  // valid never depends on ready, and the dispatch fields are held while valid waits.
  logic                    issue_valid_i;
  logic                    issue_ready_o;
  logic [31:0]             issue_instr_i;
  logic [ID_WIDTH-1:0]     issue_id_i;
  xif_pkg::x_issue_resp_t  issue_resp_o;
  logic                    commit_valid_i;
  logic [ID_WIDTH-1:0]     commit_id_i;
  logic                    commit_kill_i;
  logic                    disp_valid_o;
  logic                    disp_ready_i;
  logic [31:0]             disp_instr_o;
  logic [ID_WIDTH-1:0]     disp_id_o;
  instr_class_e            disp_class_o;

  modport master (
    output issue_valid_i, issue_instr_i, issue_id_i,
    output commit_valid_i, commit_id_i, commit_kill_i, disp_ready_i,
    input  issue_ready_o, issue_resp_o,
    input  disp_valid_o, disp_instr_o, disp_id_o, disp_class_o
  );

  modport slave (
    input  issue_valid_i, issue_instr_i, issue_id_i,
    input  commit_valid_i, commit_id_i, commit_kill_i, disp_ready_i,
    output issue_ready_o, issue_resp_o,
    output disp_valid_o, disp_instr_o, disp_id_o, disp_class_o
  );

endinterface

// File: rtl/quadrilatero_instr_classifier.sv
// Combinational decode of an offloaded word into class and XIF issue response.
// MCFG* encodings are recognised only when QUADRILATERO_MCFG_EN is defined.
module quadrilatero_instr_classifier
  import quadrilatero_pkg::*;
  import quadrilatero_instr_pkg::*;
#(
  parameter bit FP_EN = 1'b1
) (
  input  logic [31:0]            instr_i,
  output instr_class_e           class_o,
  output xif_pkg::x_issue_resp_t resp_o
);

  instr_class_e cls;

  always_comb begin
    cls = NONE;
    casez (instr_i)
      MMAQA_B, MMADA_H, MMASA_W:    cls = MAC;
      FMMACC_B, FMMACC_H, FMMACC_S: cls = FMAC;
      MZERO:                        cls = ZERO;
      MLD_W:                        cls = LOAD;
      MST_B, MST_H, MST_W:          cls = STORE;
`ifdef QUADRILATERO_MCFG_EN
      MCFG, MCFGK, MCFGKI, MCFGM, MCFGMI, MCFGN, MCFGNI: cls = CFG;
`endif
      default:                      cls = NONE;
    endcase
  end

  always_comb begin
    resp_o = ISSUE_RESP_DEFAULT;
    if (cls != NONE && !(cls == FMAC && !FP_EN)) begin
      resp_o.accept    = 1'b1;
      resp_o.loadstore = (cls == LOAD) || (cls == STORE);
      resp_o.writeback = (cls == CFG);
    end
  end

  assign class_o = cls;

endmodule

// File: rtl/quadrilatero_xif_issue_stage.sv
// XIF issue stage: classifies offloads, queues accepted ones in order, and dispatches
// committed heads. QUADRILATERO_MCFG_EN enables the MCFG* configuration class.
module quadrilatero_xif_issue_stage
  import quadrilatero_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned ID_WIDTH = 4,
  parameter bit          FP_EN    = 1'b1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  quadrilatero_xif_issue_stage_if.slave xif,
  output logic [$clog2(DEPTH):0]   outstanding_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  queue_entry_t           q [DEPTH];
  logic [DEPTH-1:0]       q_valid;
  logic [PTR_W-1:0]       wr_ptr, rd_ptr;
  logic [CNT_W-1:0]       count;

  instr_class_e           cls;
  xif_pkg::x_issue_resp_t resp;
  logic                   push, pop, kill_pop, disp_valid, new_commit;
  logic [MAX_ID_WIDTH-1:0] commit_id_ext, issue_id_ext;

  quadrilatero_instr_classifier #(.FP_EN(FP_EN)) u_classifier (
    .instr_i (xif.issue_instr_i),
    .class_o (cls),
    .resp_o  (resp)
  );

  assign commit_id_ext = MAX_ID_WIDTH'(xif.commit_id_i);
  assign issue_id_ext  = MAX_ID_WIDTH'(xif.issue_id_i);

  assign xif.issue_resp_o  = resp;
  assign xif.issue_ready_o = (count < CNT_W'(DEPTH));
  assign push = xif.issue_valid_i & xif.issue_ready_o & resp.accept;

  // A killed head is dropped silently; only a committed, live head is offered.
  assign kill_pop   = q_valid[rd_ptr] & q[rd_ptr].killed;
  assign disp_valid = q_valid[rd_ptr] & q[rd_ptr].committed & ~q[rd_ptr].killed;
  assign pop        = kill_pop | (disp_valid & xif.disp_ready_i);

  // A commit naming the id being pushed this cycle lands on the new entry.
  assign new_commit = xif.commit_valid_i && (commit_id_ext == issue_id_ext);

  assign xif.disp_valid_o = disp_valid;
  assign xif.disp_instr_o = q[rd_ptr].instr;
  assign xif.disp_id_o    = q[rd_ptr].id[ID_WIDTH-1:0];
  assign xif.disp_class_o = q[rd_ptr].cls;
  assign outstanding_o    = count;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
      q_valid <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (q_valid[i] && xif.commit_valid_i && (q[i].id == commit_id_ext)) begin
          q[i].committed <= 1'b1;
          q[i].killed    <= xif.commit_kill_i;
        end
      end
      if (pop) begin
        q_valid[rd_ptr] <= 1'b0;
        rd_ptr          <= rd_ptr + PTR_W'(1);
      end
      if (push) begin
        q[wr_ptr].instr     <= xif.issue_instr_i;
        q[wr_ptr].id        <= issue_id_ext;
        q[wr_ptr].cls       <= cls;
        q[wr_ptr].committed <= new_commit;
        q[wr_ptr].killed    <= new_commit & xif.commit_kill_i;
        q_valid[wr_ptr]     <= 1'b1;
        wr_ptr              <= wr_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

endmodule

// File: tb/tb_quadrilatero_xif_issue_stage.sv
// Directed bench for quadrilatero_xif_issue_stage (FP_EN=1 main DUT, FP_EN=0 companion).
module tb_quadrilatero_xif_issue_stage;
  import quadrilatero_pkg::*;
  import xif_pkg::*;

  localparam int unsigned W = 32 + 4 + 3;

  localparam logic [31:0] W_MMAQA_B  = 32'h0000_002B;
  localparam logic [31:0] W_MMASA_W  = 32'h0400_002B;
  localparam logic [31:0] W_FMMACC_S = 32'h0C00_002B;
  localparam logic [31:0] W_MZERO    = 32'h1000_002B;
  localparam logic [31:0] W_MLD_W    = 32'h0000_102B;
  localparam logic [31:0] W_MST_W    = 32'h0400_202B;
  localparam logic [31:0] W_MCFG     = 32'h0000_302B;
  localparam logic [31:0] W_ADDI     = 32'h0000_0013;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  quadrilatero_xif_issue_stage_if #(.ID_WIDTH(4)) bus ();
  quadrilatero_xif_issue_stage_if #(.ID_WIDTH(4)) bus2 ();
  logic [2:0] outstanding, outstanding2;

  quadrilatero_xif_issue_stage #(.DEPTH(4), .ID_WIDTH(4), .FP_EN(1'b1)) dut (
    .clk_i(clk), .rst_ni(rst_n), .xif(bus), .outstanding_o(outstanding));

  quadrilatero_xif_issue_stage #(.DEPTH(4), .ID_WIDTH(4), .FP_EN(1'b0)) dut_nofp (
    .clk_i(clk), .rst_ni(rst_n), .xif(bus2), .outstanding_o(outstanding2));

  assign bus2.issue_valid_i  = bus.issue_valid_i;
  assign bus2.issue_instr_i  = bus.issue_instr_i;
  assign bus2.issue_id_i     = bus.issue_id_i;
  assign bus2.commit_valid_i = bus.commit_valid_i;
  assign bus2.commit_id_i    = bus.commit_id_i;
  assign bus2.commit_kill_i  = bus.commit_kill_i;
  assign bus2.disp_ready_i   = bus.disp_ready_i;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] mk_exp(input logic [31:0] instr, input logic [3:0] id,
                                          input instr_class_e c);
    return {instr, id, c};
  endfunction

  always @(negedge clk) begin
    if (rst_n && bus.disp_valid_o && bus.disp_ready_i) begin
      check_eq("disp_expected", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0)
        check_eq("disp_fields", {bus.disp_instr_o, bus.disp_id_o, bus.disp_class_o},
                 exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  x_issue_resp_t r, r2;
  logic rdy, rdy2;

  task automatic drive_cycle(input logic iv, input logic [31:0] instr, input logic [3:0] id,
                             input logic cv, input logic [3:0] cid, input logic ckill);
    bus.issue_valid_i  = iv;
    bus.issue_instr_i  = instr;
    bus.issue_id_i     = id;
    bus.commit_valid_i = cv;
    bus.commit_id_i    = cid;
    bus.commit_kill_i  = ckill;
    #2;
    r    = bus.issue_resp_o;
    rdy  = bus.issue_ready_o;
    r2   = bus2.issue_resp_o;
    rdy2 = bus2.issue_ready_o;
    @(posedge clk);
    #1;
    bus.issue_valid_i  = 1'b0;
    bus.commit_valid_i = 1'b0;
    bus.commit_kill_i  = 1'b0;
  endtask

  task automatic issue(input logic [31:0] instr, input logic [3:0] id);
    drive_cycle(1'b1, instr, id, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic commit(input logic [3:0] id, input logic kill);
    drive_cycle(1'b0, 32'h0, 4'd0, 1'b1, id, kill);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b0;
    bus.issue_valid_i = 1'b0; bus.issue_instr_i = '0; bus.issue_id_i = '0;
    bus.commit_valid_i = 1'b0; bus.commit_id_i = '0; bus.commit_kill_i = 1'b0;
    bus.disp_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check_eq("rst_outstanding", outstanding, 0);
    check_eq("rst_disp_valid", bus.disp_valid_o, 0);
    check_eq("rst_ready", bus.issue_ready_o, 1);
    check_eq("rst_outstanding_nofp", outstanding2, 0);

    // single MAC: issue, commit, dispatch
    exp_q.push_back(mk_exp(W_MMAQA_B, 4'd3, MAC));
    issue(W_MMAQA_B, 4'd3);
    check_eq("mac_accept", r.accept, 1);
    check_eq("mac_loadstore", r.loadstore, 0);
    check_eq("mac_writeback", r.writeback, 0);
    check_eq("mac_ready", rdy, 1);
    check_eq("mac_outstanding", outstanding, 1);
    check_eq("mac_uncommitted_stall", bus.disp_valid_o, 0);
    commit(4'd3, 1'b0);
    check_eq("mac_disp_valid", bus.disp_valid_o, 1);
    check_eq("mac_disp_id", bus.disp_id_o, 3);
    check_eq("mac_disp_class", bus.disp_class_o, MAC);
    idle(1);
    check_eq("mac_drained", outstanding, 0);

    // load then store, committed out of order, dispatched in order
    exp_q.push_back(mk_exp(W_MLD_W, 4'd1, LOAD));
    exp_q.push_back(mk_exp(W_MST_W, 4'd2, STORE));
    issue(W_MLD_W, 4'd1);
    check_eq("ld_loadstore", r.loadstore, 1);
    check_eq("ld_accept", r.accept, 1);
    issue(W_MST_W, 4'd2);
    check_eq("st_loadstore", r.loadstore, 1);
    commit(4'd2, 1'b0);
    check_eq("order_head_stall", bus.disp_valid_o, 0);
    idle(2);
    check_eq("order_head_stall2", bus.disp_valid_o, 0);
    check_eq("order_outstanding", outstanding, 2);
    commit(4'd1, 1'b0);
    check_eq("order_first_id", bus.disp_id_o, 1);
    idle(1);
    check_eq("order_second_valid", bus.disp_valid_o, 1);
    check_eq("order_second_id", bus.disp_id_o, 2);
    idle(1);
    check_eq("order_drained", outstanding, 0);

    // killed entry is dropped without dispatch
    issue(W_MZERO, 4'd5);
    check_eq("zero_accept", r.accept, 1);
    check_eq("zero_outstanding", outstanding, 1);
    commit(4'd5, 1'b1);
    check_eq("kill_no_disp", bus.disp_valid_o, 0);
    idle(1);
    check_eq("kill_drained", outstanding, 0);
    check_eq("kill_no_disp2", bus.disp_valid_o, 0);

    // commit in the same cycle as the push of that id
    exp_q.push_back(mk_exp(W_MMAQA_B, 4'd6, MAC));
    drive_cycle(1'b1, W_MMAQA_B, 4'd6, 1'b1, 4'd6, 1'b0);
    check_eq("same_cycle_disp_valid", bus.disp_valid_o, 1);
    check_eq("same_cycle_disp_id", bus.disp_id_o, 6);
    idle(1);
    check_eq("same_cycle_drained", outstanding, 0);

    // fill to DEPTH, fifth request sees ready low; pointers wrap here
    for (int i = 0; i < 4; i++) begin
      issue(W_MMASA_W, 4'(8 + i));
      check_eq("fill_ready", rdy, 1);
    end
    check_eq("full_outstanding", outstanding, 4);
    check_eq("full_ready", bus.issue_ready_o, 0);
    issue(W_MMASA_W, 4'd12);
    check_eq("full_req_ready", rdy, 0);
    check_eq("full_not_queued", outstanding, 4);
    exp_q.push_back(mk_exp(W_MMASA_W, 4'd8, MAC));
    commit(4'd8, 1'b0);
    check_eq("full_disp_id", bus.disp_id_o, 8);
    idle(1);
    check_eq("full_ready_back", bus.issue_ready_o, 1);
    check_eq("full_after_pop", outstanding, 3);
    commit(4'd9, 1'b1);
    commit(4'd10, 1'b1);
    commit(4'd11, 1'b1);
    idle(2);
    check_eq("full_drained", outstanding, 0);

    // unmatched commit is ignored
    issue(W_MMAQA_B, 4'd14);
    commit(4'd15, 1'b0);
    check_eq("unmatched_no_disp", bus.disp_valid_o, 0);
    check_eq("unmatched_outstanding", outstanding, 1);
    commit(4'd14, 1'b1);
    idle(1);
    check_eq("unmatched_drained", outstanding, 0);

    // rejected instructions: non-matrix word, FMAC with FP_EN=0
    issue(W_ADDI, 4'd0);
    check_eq("addi_resp_zero", r, 0);
    check_eq("addi_ready", rdy, 1);
    check_eq("addi_not_queued", outstanding, 0);
    issue(W_FMMACC_S, 4'd13);
    check_eq("fmac_fp_accept", r.accept, 1);
    check_eq("fmac_nofp_resp_zero", r2, 0);
    check_eq("fmac_nofp_ready", rdy2, 1);
    check_eq("fmac_fp_queued", outstanding, 1);
    check_eq("fmac_nofp_not_queued", outstanding2, 0);
    commit(4'd13, 1'b1);
    idle(1);
    check_eq("fmac_drained", outstanding, 0);

    // configuration class
    issue(W_MCFG, 4'd7);
`ifdef QUADRILATERO_MCFG_EN
    check_eq("mcfg_accept", r.accept, 1);
    check_eq("mcfg_writeback", r.writeback, 1);
    check_eq("mcfg_loadstore", r.loadstore, 0);
    check_eq("mcfg_queued", outstanding, 1);
    commit(4'd7, 1'b1);
    idle(1);
    check_eq("mcfg_drained", outstanding, 0);
`else
    check_eq("mcfg_resp_zero", r, 0);
    check_eq("mcfg_not_queued", outstanding, 0);
`endif

    // asynchronous reset mid-operation discards entries
    issue(W_MMAQA_B, 4'd2);
    issue(W_MZERO, 4'd4);
    check_eq("arst_pre", outstanding, 2);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_outstanding", outstanding, 0);
    check_eq("arst_disp_valid", bus.disp_valid_o, 0);
    check_eq("arst_ready", bus.issue_ready_o, 1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    commit(4'd2, 1'b0);
    check_eq("arst_entry_gone", bus.disp_valid_o, 0);

    idle(2);
    check_eq("exp_q_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/quadrilatero_xif_issue_stage.md
Name: quadrilatero_xif_issue_stage

Overview:
- Successor to the combinational XIF issue decoder.
- Classifies offloaded instructions, generates the issue response, and buffers accepted instructions in a DEPTH-entry in-order queue tagged with the XIF id.
- Tracks the XIF commit/kill result per entry. Only committed, non-killed instructions are dispatched to the matrix controller.
- Sits between the core's XIF issue/commit ports and the quadrilatero dispatcher.

Parameters:
- DEPTH, 4, queue entries; power of two, minimum 2.
- ID_WIDTH, 4, XIF instruction id width.
- FP_EN, 1, when 0 FMMACC_B/H/S are rejected (accept=0).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- issue_valid_i  in  1  XIF issue request valid
- issue_ready_o  out  1  issue handshake ready
- issue_instr_i  in  32  instruction word
- issue_id_i  in  ID_WIDTH  instruction id
- issue_resp_o  out  xif_pkg::x_issue_resp_t  issue response, valid with handshake
- commit_valid_i  in  1  commit valid
- commit_id_i  in  ID_WIDTH  committed id
- commit_kill_i  in  1  kill flag
- disp_valid_o  out  1  head instruction ready for dispatch
- disp_ready_i  in  1  dispatcher accepts
- disp_instr_o  out  32  head instruction word
- disp_id_o  out  ID_WIDTH  head id
- disp_class_o  out  quadrilatero_pkg::instr_class_e  head class
- outstanding_o  out  $clog2(DEPTH)+1  occupied entries

Behaviour:
- Reset: queue empty; all valid/committed/killed bits 0; disp_valid_o=0; outstanding_o=0; pointers 0.
- Classes: MAC (MMAQA_B, MMADA_H, MMASA_W), FMAC (FMMACC_*), LOAD (MLD_W), STORE (MST_B/H/W), ZERO (MZERO), CFG (optional feature), NONE.
- Issue response is combinational in the same cycle as issue_valid_i:
  - Known class: accept=1, loadstore=1 for LOAD/STORE, writeback=1 for CFG only, all other fields 0.
  - NONE, or FMAC with FP_EN=0: response all zero.
- issue_ready_o = (count < DEPTH), registered-count based. A push in the same cycle as a pop while full is not allowed.
- Rejected instructions with ready high complete the handshake and are not queued.
- Push on issue_valid_i & issue_ready_o & accept. The entry stores instr, id, class, committed=0, killed=0. Push latency to earliest dispatch is 1 cycle.
- Commit: on commit_valid_i, every valid entry with matching id sets committed=1 and killed=commit_kill_i.
  - A commit matching the id being pushed in the same cycle applies to the new entry.
  - A commit with no matching id is ignored.
- Head handling:
  - Head valid & killed: popped internally that cycle; disp_valid_o stays 0.
  - Head valid & committed & !killed: disp_valid_o=1 with its fields held stable until disp_ready_i.
  - Pop on disp_valid_o & disp_ready_i.
- Pointers wrap modulo DEPTH. outstanding_o = count, updated with each push/pop. Simultaneous push and pop leaves count unchanged.
- Uncommitted head stalls dispatch (in-order); younger committed entries wait behind it.
- Asynchronous reset mid-operation discards all entries immediately.

Optional Feature:
- QUADRILATERO_MCFG_EN.
- Defined: MCFG, MCFGK, MCFGKI, MCFGM, MCFGMI, MCFGN, MCFGNI decode as CFG with accept=1, writeback=1, and are queued like other classes.
- Undefined: these encodings are treated as NONE (response all zero, not queued).

Decomposition:
- quadrilatero_pkg holds:
  - instr_class_e enum (NONE, MAC, FMAC, LOAD, STORE, ZERO, CFG)
  - queue entry struct (instr, id, class, committed, killed)
  - default issue response constant
- Instruction encodings remain in quadrilatero_instr_pkg.
- One combinational sub-module, quadrilatero_instr_classifier: instr_i -> class + x_issue_resp_t. It is reused by the issue stage and the register-file scoreboard.

Test Plan:
- Issue MMAQA_B id=3, commit id=3 kill=0, disp_ready=1 -> accept=1, loadstore=0; disp_valid_o high the cycle after commit with id 3, class MAC; outstanding returns to 0.
- Issue MLD_W id=1 then MST_W id=2, commit id=2 first, then id=1 -> loadstore=1 both; dispatch order id1 then id2; nothing dispatched before id1 commits.
- Issue MZERO id=5, commit id=5 kill=1 -> entry dropped; disp_valid_o never asserts; outstanding 1 -> 0.
- Fill with DEPTH=4 issues, no commits -> issue_ready_o=0 on the 5th request; after one commit+dispatch, ready returns to 1.
- Issue 0x00000013 (addi) and, with FP_EN=0, FMMACC_S -> response all zero, ready=1, outstanding unchanged.
- Issue MCFG id=7 -> with QUADRILATERO_MCFG_EN: accept=1, writeback=1, queued; without it: response zero.
